// File: rtl/mips_debug_pkg.sv
// Shared debug-path definitions: program-loader FSM encodings, HALT marker and byte-lane helpers.
// Also imported by DebugUnit; keep encodings stable.
package mips_debug_pkg;

    typedef enum logic [1:0] {
        LDR_IDLE  = 2'd0,
        LDR_LOAD  = 2'd1,
        LDR_WRITE = 2'd2,
        LDR_DONE  = 2'd3
    } ldr_state_t;

    localparam logic [31:0] LDR_HALT_WORD  = 32'hFC00_0000;
    localparam int          LDR_BYTE_CNT_W = 2;

    // Bytes arrive MSB-first, so each new byte lands in the low lane.
    function automatic logic [31:0] ldr_shift_in(input logic [31:0] word, input logic [7:0] rx_byte);
        return {word[23:0], rx_byte};
    endfunction

    function automatic logic ldr_last_byte(input logic [LDR_BYTE_CNT_W-1:0] byte_cnt);
        return (byte_cnt == {LDR_BYTE_CNT_W{1'b1}});
    endfunction

endpackage

// File: rtl/loader_idle_timer.sv
// Idle-gap counter for the program loader: clear has priority, counts while enabled,
// and flags expiry on the cycle the count reaches LIMIT-1 (one more idle cycle would hit LIMIT).
module loader_idle_timer #(
    parameter int LIMIT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] count_r;

    // Idle-cycle counter, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en) begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    assign expired = en && !clr && (count_r == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/uart_program_loader.sv
// Assembles UART bytes into 32-bit words and writes them to instruction memory at incrementing addresses.
// Optional idle-gap timeout is built only when PROG_LOADER_TIMEOUT_EN is defined.
module uart_program_loader
    import mips_debug_pkg::*;
#(
    parameter int          ADDR_W         = 8,
    parameter logic [31:0] HALT_WORD      = LDR_HALT_WORD,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic [31:0]       instr_data,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              instr_wr,
    output logic              busy,
    output logic              done,
    output logic              error
);

    ldr_state_t                state_r;
    logic [ADDR_W-1:0]         addr_r;
    logic [LDR_BYTE_CNT_W-1:0] byte_cnt_r;
    logic [31:0]               word_r;
    logic [31:0]               instr_data_r;
    logic [ADDR_W-1:0]         instr_addr_r;
    logic                      instr_wr_r;
    logic                      busy_r;
    logic                      done_r;
    logic                      error_r;
    logic                      timeout_s;
    logic                      last_addr_s;

    assign last_addr_s = (addr_r == {ADDR_W{1'b1}});

`ifdef PROG_LOADER_TIMEOUT_EN
    logic timer_clr_s;
    logic timer_en_s;

    assign timer_clr_s = rx_done || (state_r != LDR_LOAD);
    assign timer_en_s  = (state_r == LDR_LOAD) && (byte_cnt_r != {LDR_BYTE_CNT_W{1'b0}});

    loader_idle_timer #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr_s),
        .en      (timer_en_s),
        .expired (timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // Loader FSM with all outputs registered; the write strobe is raised on the edge that
    // captures the 4th byte so memory sees it the very next cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= LDR_IDLE;
            addr_r       <= {ADDR_W{1'b0}};
            byte_cnt_r   <= {LDR_BYTE_CNT_W{1'b0}};
            word_r       <= 32'h0000_0000;
            instr_data_r <= 32'h0000_0000;
            instr_addr_r <= {ADDR_W{1'b0}};
            instr_wr_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            instr_wr_r <= 1'b0;
            case (state_r)
                LDR_IDLE, LDR_DONE: begin
                    if (start) begin
                        state_r    <= LDR_LOAD;
                        addr_r     <= {ADDR_W{1'b0}};
                        byte_cnt_r <= {LDR_BYTE_CNT_W{1'b0}};
                        word_r     <= 32'h0000_0000;
                        busy_r     <= 1'b1;
                        done_r     <= 1'b0;
                        error_r    <= 1'b0;
                    end
                end
                LDR_LOAD: begin
                    if (timeout_s) begin
                        state_r    <= LDR_DONE;
                        byte_cnt_r <= {LDR_BYTE_CNT_W{1'b0}};
                        word_r     <= 32'h0000_0000;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        error_r    <= 1'b1;
                    end else if (rx_done) begin
                        word_r     <= ldr_shift_in(word_r, rx_data);
                        byte_cnt_r <= byte_cnt_r + LDR_BYTE_CNT_W'(1);
                        if (ldr_last_byte(byte_cnt_r)) begin
                            state_r      <= LDR_WRITE;
                            instr_wr_r   <= 1'b1;
                            instr_data_r <= ldr_shift_in(word_r, rx_data);
                            instr_addr_r <= addr_r;
                        end
                    end
                end
                LDR_WRITE: begin
                    if (word_r == HALT_WORD) begin
                        state_r <= LDR_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else if (last_addr_s) begin
                        state_r <= LDR_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        error_r <= 1'b1;
                    end else begin
                        state_r <= LDR_LOAD;
                        addr_r  <= addr_r + ADDR_W'(1);
                        // A byte landing in the write cycle is byte 0 of the next word.
                        if (rx_done) begin
                            word_r     <= ldr_shift_in(word_r, rx_data);
                            byte_cnt_r <= LDR_BYTE_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_r <= LDR_IDLE;
                end
            endcase
        end
    end

    assign instr_data = instr_data_r;
    assign instr_addr = instr_addr_r;
    assign instr_wr   = instr_wr_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader (ADDR_W=2, TIMEOUT_CYCLES=100); expected writes come
// from a byte-stream reference model. Timeout scenario follows PROG_LOADER_TIMEOUT_EN.
module tb_uart_program_loader;

    localparam int          AW   = 2;
    localparam logic [31:0] HALT = 32'hFC00_0000;
    localparam int          TO   = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_done = 1'b0;
    logic [31:0]   instr_data;
    logic [AW-1:0] instr_addr;
    logic          instr_wr;
    logic          busy;
    logic          done;
    logic          error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW+31:0] wr_q[$];
    logic [AW+31:0] exp_q[$];
    logic [7:0]     sent_q[$];
    logic           exp_done;
    logic           exp_err;
    logic           prev_wr = 1'b0;
    int             consec = 0;

    uart_program_loader #(
        .ADDR_W         (AW),
        .HALT_WORD      (HALT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .instr_data (instr_data),
        .instr_addr (instr_addr),
        .instr_wr   (instr_wr),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Capture every memory write away from the active edge.
    always @(negedge clk) begin
        if (instr_wr === 1'b1) wr_q.push_back({instr_addr, instr_data});
        if (instr_wr === 1'b1 && prev_wr === 1'b1) consec <= consec + 1;
        prev_wr <= instr_wr;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit model);
        rx_data = b;
        rx_done = 1'b1;
        if (model) sent_q.push_back(b);
        tick();
        rx_done = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gap, 1'b1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic begin_load();
        sent_q.delete();
        wr_q.delete();
        pulse_start();
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = w ^ 32'h0000_0001;
        return w;
    endfunction

    // Reference: group sent bytes in fours, address them 0,1,..; stop at HALT or after the last address.
    task automatic model_run();
        logic [31:0]   w;
        logic [AW-1:0] a;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        for (int i = 0; i + 3 < sent_q.size(); i += 4) begin
            w = {sent_q[i], sent_q[i+1], sent_q[i+2], sent_q[i+3]};
            a = AW'(i / 4);
            exp_q.push_back({a, w});
            if (w == HALT) begin
                exp_done = 1'b1;
                break;
            end
            if ((i / 4) == (2**AW - 1)) begin
                exp_done = 1'b1;
                exp_err  = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 300 && done !== 1'b1; k++) tick();
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_wait: done=%b required 1 within 300 cycles", name, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({instr_data, instr_addr, instr_wr, busy, done, error} !== {(AW+36){1'b0}}) begin
            n_fail++;
            $display("FAIL reset_outputs: data=%h addr=%0d wr=%b busy=%b done=%b err=%b required all 0",
                     instr_data, instr_addr, instr_wr, busy, done, error);
        end
        rst = 1'b1;
        tick();
        wr_q.delete();
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1, 1'b0);
        n_checks++;
        if (wr_q.size() != 0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_bytes: writes=%0d busy=%b done=%b required 0/0/0", wr_q.size(), busy, done);
        end
    endtask

    task automatic test_basic();
        logic [7:0] prog [8];
        prog = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFC, 8'h00, 8'h00, 8'h00};
        begin_load();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: busy=%b required 1", busy);
        end
        foreach (prog[i]) send_byte(prog[i], 2, 1'b1);
        wait_done("basic");
        exp_q = '{{2'd0, 32'h2001_0005}, {2'd1, 32'hFC00_0000}};
        n_checks++;
        if (wr_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_wr_count: got %0d required %0d", wr_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < wr_q.size()) begin
            n_checks++;
            if (wr_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL basic_wr[%0d]: got %h required %h", i, wr_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if ({done, error, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL basic_flags: done/err/busy=%b required 100", {done, error, busy});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w0;
        logic [31:0] w1;
        w0 = rand_word();
        w1 = rand_word();
        begin_load();
        send_word(w0, 0);
        send_word(w1, 0);
        send_word(HALT, 0);
        wait_done("b2b");
        exp_q = '{{2'd0, w0}, {2'd1, w1}, {2'd2, HALT}};
        n_checks++;
        if (wr_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_wr_count: got %0d required %0d", wr_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < wr_q.size()) begin
            n_checks++;
            if (wr_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b_wr[%0d]: got %h required %h", i, wr_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] w [5];
        foreach (w[i]) w[i] = rand_word();
        begin_load();
        foreach (w[i]) send_word(w[i], $urandom_range(0, 2));
        wait_done("ovf");
        n_checks++;
        if (wr_q.size() != 4) begin
            n_fail++;
            $display("FAIL ovf_wr_count: got %0d required 4", wr_q.size());
        end
        for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
            n_checks++;
            if (wr_q[i] !== {AW'(i), w[i]}) begin
                n_fail++;
                $display("FAIL ovf_wr[%0d]: got %h required %h", i, wr_q[i], {AW'(i), w[i]});
            end
        end
        n_checks++;
        if ({done, error, busy} !== 3'b110) begin
            n_fail++;
            $display("FAIL ovf_flags: done/err/busy=%b required 110", {done, error, busy});
        end
    endtask

    task automatic test_ignored();
        logic [31:0] w0;
        logic [31:0] w1;
        w0 = rand_word();
        w1 = rand_word();
        wr_q.delete();
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0, 1'b0);
        n_checks++;
        if (wr_q.size() != 0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_bytes: writes=%0d done=%b required 0 writes, done 1", wr_q.size(), done);
        end
        // start and a byte in the same cycle: the byte is dropped
        sent_q.delete();
        start   = 1'b1;
        rx_data = 8'hAA;
        rx_done = 1'b1;
        tick();
        start   = 1'b0;
        rx_done = 1'b0;
        tick();
        send_word(w0, 1);
        pulse_start();
        send_word(w1, 1);
        send_byte(HALT[31:24], 1, 1'b1);
        send_byte(HALT[23:16], 1, 1'b1);
        pulse_start();
        send_byte(HALT[15:8], 1, 1'b1);
        send_byte(HALT[7:0], 1, 1'b1);
        wait_done("ign");
        model_run();
        n_checks++;
        if (wr_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL ign_wr_count: got %0d required %0d", wr_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < wr_q.size()) begin
            n_checks++;
            if (wr_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL ign_wr[%0d]: got %h required %h", i, wr_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_midload();
        begin_load();
        for (int i = 0; i < 3; i++) send_word(rand_word(), $urandom_range(0, 2));
        send_byte(8'($urandom), 1, 1'b0);
        send_byte(8'($urandom), 1, 1'b0);
        rst = 1'b0;
        tick();
        n_checks++;
        if ({instr_data, instr_addr, instr_wr, busy, done, error} !== {(AW+36){1'b0}}) begin
            n_fail++;
            $display("FAIL midload_reset: data=%h addr=%0d wr=%b busy=%b done=%b err=%b required all 0",
                     instr_data, instr_addr, instr_wr, busy, done, error);
        end
        rst = 1'b1;
        tick();
        begin_load();
        send_word(HALT, 1);
        wait_done("midload");
        n_checks++;
        if (wr_q.size() != 1 || wr_q[0] !== {AW'(0), HALT} || error !== 1'b0) begin
            n_fail++;
            $display("FAIL midload_reload: writes=%0d first=%h err=%b required 1 write of %h, err 0",
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : {(AW+32){1'b0}}, error, {AW'(0), HALT});
        end
    endtask

    task automatic test_timeout();
        logic [31:0] w;
        w = rand_word();
        begin_load();
        send_byte(w[31:24], 0, 1'b1);
        send_byte(w[23:16], 0, 1'b1);
`ifdef PROG_LOADER_TIMEOUT_EN
        begin
            int k;
            for (k = 1; k <= 200; k++) begin
                tick();
                if (done === 1'b1) break;
            end
            n_checks++;
            if (k != TO) begin
                n_fail++;
                $display("FAIL timeout_latency: done after %0d cycles required %0d", k, TO);
            end
            n_checks++;
            if ({done, error, busy} !== 3'b110 || wr_q.size() != 0) begin
                n_fail++;
                $display("FAIL timeout_flags: done/err/busy=%b writes=%0d required 110 and 0 writes",
                         {done, error, busy}, wr_q.size());
            end
        end
`else
        repeat (TO + 50) tick();
        n_checks++;
        if ({done, error, busy} !== 3'b001 || wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL no_timeout_wait: done/err/busy=%b writes=%0d required 001 and 0 writes",
                     {done, error, busy}, wr_q.size());
        end
        send_byte(w[15:8], 1, 1'b1);
        send_byte(w[7:0], 1, 1'b1);
        send_word(HALT, 1);
        wait_done("no_timeout");
        n_checks++;
        if (wr_q.size() != 2 || wr_q[0] !== {AW'(0), w} || error !== 1'b0) begin
            n_fail++;
            $display("FAIL no_timeout_word: writes=%0d first=%h err=%b required 2 writes, first %h, err 0",
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : {(AW+32){1'b0}}, error, {AW'(0), w});
        end
`endif
    endtask

    task automatic test_random_programs();
        for (int it = 0; it < 20; it++) begin
            int nw;
            nw = $urandom_range(0, 5);
            begin_load();
            for (int j = 0; j < nw; j++) send_word(rand_word(), $urandom_range(0, 3));
            send_word(HALT, $urandom_range(0, 3));
            for (int j = 0; j < 3; j++) send_byte(8'($urandom), 0, 1'b1);
            wait_done("rand");
            model_run();
            n_checks++;
            if (wr_q.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL rand%0d_wr_count: got %0d required %0d", it, wr_q.size(), exp_q.size());
            end
            foreach (exp_q[i]) if (i < wr_q.size()) begin
                n_checks++;
                if (wr_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d_wr[%0d]: got %h required %h", it, i, wr_q[i], exp_q[i]);
                end
            end
            n_checks++;
            if ({done, error, busy} !== {exp_done, exp_err, 1'b0}) begin
                n_fail++;
                $display("FAIL rand%0d_flags: done/err/busy=%b required %b",
                         it, {done, error, busy}, {exp_done, exp_err, 1'b0});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_ignored();
        test_reset_midload();
        test_timeout();
        test_random_programs();
        tick();
        n_checks++;
        if (consec != 0) begin
            n_fail++;
            $display("FAIL wr_consecutive: %0d back-to-back strobes required 0", consec);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
